// File: rtl/uart_pkg.sv
// Shared types and clocking constants for the UART receive path.
// UART_RX_PARITY_EN adds the even-parity state to the receiver state set.
package uart_pkg;

    localparam int CLK_HZ   = 125000000;
    localparam int BAUD     = 115200;
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/baudgen_rx.sv
// Mid-bit baud tick generator: counts only while enabled and ticks halfway
// through each bit period so the receiver samples at bit centres.
module baudgen_rx #(
    parameter int BAUDRATE = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic ena,
    output logic tick
);

    localparam int CW = $clog2(BAUDRATE);
    localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] MID  = CW'(BAUDRATE / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!ena) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = ena && (cnt_q == MID);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, frames LSB-first words and strobes valid/error flags.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUDRATE  = BAUD_DIV,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 par_bad;
    logic                 tick;

    baudgen_rx #(.BAUDRATE(BAUDRATE)) u_baudgen (
        .clk  (clk),
        .rstn (rstn),
        .ena  (busy_q),
        .tick (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic parity_err_q, parity_err_d;
    assign par_bad    = (^shreg_q) != par_bit_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    par_bit_d = rx_s_q;
                    state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
                if (tick) begin
                    rx_data_d   = shreg_q;
                    rx_valid_d  = rx_s_q && !par_bad;
                    frame_err_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad;
`endif
                    state_d     = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUDRATE=16: serial frames are generated from
// a bit-level line model and each expected result is queued for an independent monitor.
module tb_uart_rx;

    localparam int B = 16;
    localparam int N = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Line goes low just after a falling edge; first sampling edge is one cycle later.
    localparam int LAT = 1 + 3 + B/2 + (N + 1 + PB) * B;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    exp_t       sb[$];
    exp_t       monE;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] lastData = 8'h00;

    uart_rx #(.BAUDRATE(B), .DATA_BITS(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one serial frame and queues what the receiver should report for it.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit,
                                 input logic parBit, input int gapBits);
        exp_t e;
        logic perr;
        perr    = (PB != 0) && (parBit != (^d));
        e.data  = d;
        e.ferr  = !stopBit;
        e.perr  = perr;
        e.valid = stopBit && !perr;
        e.cyc   = cyc + LAT;
        sb.push_back(e);
        lastData = d;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        if (PB != 0) begin
            rx = parBit;
            repeat (B) @(negedge clk);
        end
        rx = stopBit;
        repeat (B) @(negedge clk);
        rx = 1'b1;
        repeat (gapBits * B) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest queued frame in content and timing.
    always @(negedge clk) begin
        if (rstn && (rx_valid || frame_err || parity_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_strobe: got valid=%0b ferr=%0b perr=%0b expected none (cycle %0d)",
                         rx_valid, frame_err, parity_err, cyc);
            end else begin
                monE = sb.pop_front();
                checkOutput("rx_data", rx_data, monE.data);
                checkOutput("flags{valid,ferr,perr}", {rx_valid, frame_err, parity_err},
                            {monE.valid, monE.ferr, monE.perr});
                checks++;
                if (cyc < monE.cyc - 1 || cyc > monE.cyc + 1) begin
                    errors++;
                    $display("[TB] FAIL latency: got cycle %0d expected %0d +-1", cyc, monE.cyc);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        logic [7:0] d;
        logic stopBit, parBit;
        int gap;

        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_parity_err", parity_err, 0);
        checkOutput("reset_busy", busy, 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] frame 0x55 good stop");
        applyStimulus(8'h55, 1'b1, ^8'h55, 2);

        $display("[TB] short start glitch");
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitch_busy_high", busy, 1);
        rx = 1'b1;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("glitch_busy_drop", busy, 0);
        repeat (2 * B) @(negedge clk);

        $display("[TB] frame 0xA3 bad stop");
        applyStimulus(8'hA3, 1'b0, ^8'hA3, 2);

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00, 1'b1, ^8'h00, 0);
        applyStimulus(8'hFF, 1'b1, ^8'hFF, 2);

        $display("[TB] reset during data bit 3");
        d  = 8'hC5;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = d[3];
        repeat (B/2) @(negedge clk);
        rstn = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        checkOutput("midreset_rx_data", rx_data, 0);
        checkOutput("midreset_rx_valid", rx_valid, 0);
        checkOutput("midreset_frame_err", frame_err, 0);
        checkOutput("midreset_parity_err", parity_err, 0);
        checkOutput("midreset_busy", busy, 0);
        rstn = 1'b1;
        lastData = 8'h00;
        repeat (3 * B) @(negedge clk);
        applyStimulus(8'h3C, 1'b1, ^8'h3C, 2);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity frames 0x07");
        applyStimulus(8'h07, 1'b1, 1'b0, 2);
        applyStimulus(8'h07, 1'b1, 1'b1, 2);
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom);
            stopBit = ($urandom_range(0, 5) != 0);
            parBit  = ($urandom_range(0, 4) == 0) ? ~^d : ^d;
            gap     = stopBit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(d, stopBit, parBit, gap);
        end

        k = 0;
        while (sb.size() != 0 && k < 4 * B) begin
            @(negedge clk);
            k++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("rx_data_hold", rx_data, lastData);
        checkOutput("idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
